hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard and stall sequencer for the five-stage RISC-V core. It sits beside the decode/execute stage registers and drives their enables and flushes. It selects ALU operand forwarding from Memory/Writeback, inserts a bubble on load-use, and flushes on taken branches. It also freezes the whole pipeline while data memory is not ready, escalating to a sticky halt on timeout.

## Interface
- `TIMEOUT`, default 16: consecutive not-ready memory cycles before halt (≥2).
- `clk` input 1: core clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `RS1_D`, `RS2_D` input 5 each: source registers of the instruction in Decode.
- `RS1_E`, `RS2_E`, `RD_E` input 5 each: source and destination registers of the instruction in Execute.
- `ResultSrcE` input 1: instruction in Execute is a load.
- `PCSrcE` input 1: branch taken in Execute.
- `RD_M` input 5 and `RegWriteM` input 1: destination register and write enable in Memory.
- `RD_W` input 5 and `RegWriteW` input 1: destination register and write enable in Writeback.
- `MemReqM` input 1: load or store active in Memory.
- `dmem_ready` input 1: data memory completes the access this cycle.
- `ForwardAE`, `ForwardBE` output 2 each: 00 = register file, 01 = ResultW, 10 = ALUResultM.
- `StallF`, `StallD`, `StallE`, `StallM` output 1 each: hold the corresponding pipeline register.
- `FlushD`, `FlushE`, `FlushW` output 1 each: load a bubble into the corresponding pipeline register.
- `halt` output 1: sticky memory-timeout error.

## Operation
- Forwarding, evaluated for RS1_E→ForwardAE and independently for RS2_E→ForwardBE:
  - 10 if RegWriteM, RD_M≠0 and RD_M equals the source.
  - Otherwise 01 if RegWriteW, RD_W≠0 and RD_W equals the source.
  - Otherwise 00. Memory beats Writeback.
- lwStall = ResultSrcE, RD_E≠0, and RD_E equals RS1_D or RS2_D.
- freeze = MemReqM and not dmem_ready.
- FSM states: RUN, MEM_WAIT, HALT.
  - RUN to MEM_WAIT when freeze.
  - MEM_WAIT to RUN when dmem_ready.
  - MEM_WAIT to HALT when freeze and wait_cnt equals TIMEOUT−1.
  - HALT exits only on reset.
- wait_cnt is $clog2(TIMEOUT) bits. It increments on every freeze cycle and clears to 0 in any cycle without freeze.
- Output priority, highest first:
  1. HALT: StallF/D/E/M=1, FlushW=1, everything else 0, halt=1.
  2. freeze (RUN or MEM_WAIT): StallF/D/E/M=1, FlushW=1, FlushD/FlushE=0. A branch or load-use in the same cycle is held, not acted on.
  3. PCSrcE: FlushD=1, FlushE=1, no stalls. A branch suppresses a simultaneous lwStall because the Decode instruction is discarded.
  4. lwStall: StallF=1, StallD=1, FlushE=1.
  5. Otherwise all stall and flush outputs are 0.
- ForwardAE/BE are computed in all states except HALT and reset, where they are 00.
- Reset (asserted at any time, including mid-MEM_WAIT): state=RUN, wait_cnt=0. All outputs 0, including halt and forward selects, while rst is low.

## Timing
- Forwarding, stall and flush outputs are combinational from the current-cycle inputs and state. They are valid before the next rising edge and take effect on the stage registers at that edge.
- lwStall lasts exactly one cycle: the bubble in Execute clears ResultSrcE at the next edge.
- Branch flush costs 2 cycles (Decode and Execute bubbles).
- halt rises at the edge ending the TIMEOUT-th consecutive freeze cycle.
- dmem_ready high in the same cycle as MemReqM means no freeze and zero wait cycles.
- State and wait_cnt are updated only on rising edges. Reset acts asynchronously.

## Configuration
- `HAZARD_PERF_CNT_EN` defined adds two output ports, `stall_count` [31:0] and `flush_count` [31:0]:
  - stall_count increments on each cycle with StallF=1.
  - flush_count increments on each cycle with FlushE=1 caused by a branch.
  - Both wrap modulo 2^32 and reset to 0.
- Without the macro, neither the ports nor the counter logic exist. All other behaviour is identical.

## Structure
- Shared package `riscv_pipe_pkg` holds:
  - Forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The hazard FSM state encoding.
  - The register-index width (5).
- One sub-module, `forwarding_unit`: purely combinational, instantiated once and used for both operands (RS1_E→ForwardAE, RS2_E→ForwardBE). FSM, counters and priority logic stay in `hazard_controller`.

## Test plan
- Forwarding:
  - RegWriteM=1, RD_M=5, RS1_E=5, and RegWriteW=1, RD_W=5 → ForwardAE=10.
  - Drop RegWriteM → ForwardAE=01.
  - RD_M=RD_W=0 with RS1_E=0 → ForwardAE=00.
- Load-use: ResultSrcE=1, RD_E=7, RS2_D=7 → one cycle of StallF=StallD=FlushE=1. The next cycle (ResultSrcE=0) → all 0.
- Branch vs. load-use: PCSrcE=1 with a simultaneous lwStall → FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, dmem_ready=0 for 3 cycles with PCSrcE=1 → 3 freeze cycles, no FlushD. Then ready → flush fires that cycle and state returns to RUN.
- Timeout (TIMEOUT=16):
  - 15 not-ready cycles then ready → halt stays 0.
  - 16 not-ready cycles → halt=1 and remains 1 after ready.
  - Assert rst mid-HALT → halt=0 and state=RUN.
- With `HAZARD_PERF_CNT_EN`: 4 load-use stalls plus 2 taken branches → stall_count=4, flush_count=2.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the five-stage RISC-V core:
// forward-select codes, hazard FSM encoding and register-index width.
package riscv_pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hazardState_t;

endpackage

// File: rtl/forwarding_unit.sv
// Combinational ALU operand forwarding for both Execute sources.
// Memory-stage results take precedence over Writeback; x0 never forwards.
module forwarding_unit
  import riscv_pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs1E,
  input  logic [REG_W-1:0] rs2E,
  input  logic [REG_W-1:0] rdM,
  input  logic             regWriteM,
  input  logic [REG_W-1:0] rdW,
  input  logic             regWriteW,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB
);

  logic [1:0][REG_W-1:0] srcE;
  logic [1:0][1:0]       sel;

  assign srcE = {rs2E, rs1E};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gOperand
      logic memHit;
      logic wbHit;
      assign memHit  = regWriteM && (rdM != '0) && (rdM == srcE[gi]);
      assign wbHit   = regWriteW && (rdW != '0) && (rdW == srcE[gi]);
      assign sel[gi] = memHit ? FWD_MEM : (wbHit ? FWD_WB : FWD_RF);
    end
  endgenerate

  assign forwardA = sel[0];
  assign forwardB = sel[1];

endmodule

// File: rtl/hazard_controller.sv
// Hazard/stall sequencer: forwarding, load-use bubbles, branch flushes and
// memory-wait freeze with sticky timeout halt. HAZARD_PERF_CNT_EN adds counters.
module hazard_controller
  import riscv_pipe_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RS1_D,
  input  logic [REG_W-1:0] RS2_D,
  input  logic [REG_W-1:0] RS1_E,
  input  logic [REG_W-1:0] RS2_E,
  input  logic [REG_W-1:0] RD_E,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [REG_W-1:0] RD_M,
  input  logic             RegWriteM,
  input  logic [REG_W-1:0] RD_W,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             halt
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_count,
  output logic [31:0]      flush_count
`endif
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  hazardState_t     stateReg, stateNext;
  logic [CNT_W-1:0] waitCntReg, waitCntNext;
  logic             freeze;
  logic             lwStall;
  logic [1:0]       fwdA, fwdB;

  forwarding_unit uFwd (
    .rs1E      (RS1_E),
    .rs2E      (RS2_E),
    .rdM       (RD_M),
    .regWriteM (RegWriteM),
    .rdW       (RD_W),
    .regWriteW (RegWriteW),
    .forwardA  (fwdA),
    .forwardB  (fwdB)
  );

  assign freeze  = MemReqM && !dmem_ready;
  assign lwStall = ResultSrcE && (RD_E != '0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg   <= RUN;
      waitCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
    end
  end

  // waitCnt counts prior consecutive freeze cycles, so it reaches TIMEOUT-1
  // exactly on the TIMEOUT-th one.
  always_comb begin
    stateNext   = stateReg;
    waitCntNext = freeze ? (waitCntReg + CNT_W'(1)) : '0;
    case (stateReg)
      RUN:      if (freeze) stateNext = MEM_WAIT;
      MEM_WAIT: begin
        if (freeze && (waitCntReg == CNT_LAST)) stateNext = HALT;
        else if (dmem_ready)                    stateNext = RUN;
      end
      HALT:     stateNext = HALT;
      default:  stateNext = RUN;
    endcase
  end

  // Outputs are forced low while reset is held, even though they are combinational.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    halt      = 1'b0;
    if (rst) begin
      if (stateReg == HALT) begin
        {StallF, StallD, StallE, StallM} = 4'b1111;
        FlushW = 1'b1;
        halt   = 1'b1;
      end else begin
        ForwardAE = fwdA;
        ForwardBE = fwdB;
        if (freeze) begin
          {StallF, StallD, StallE, StallM} = 4'b1111;
          FlushW = 1'b1;
        end else if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lwStall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic branchFlush;
  assign branchFlush = rst && (stateReg != HALT) && !freeze && PCSrcE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (StallF)      stall_count <= stall_count + 32'd1;
      if (branchFlush) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios then random
// stimulus against a cycle-level reference model of the hazard rules.
module tb_hazard_controller;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic       ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, halt;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
`endif

  int errCnt   = 0;
  int checkCnt = 0;

  // Reference model: count of consecutive freeze cycles and a sticky halt flag
  int          freezeRun = 0;
  bit          halted    = 1'b0;
  int unsigned mStall    = 0;
  int unsigned mFlush    = 0;
  int          burstLeft = 0;

  hazard_controller #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .RS1_D      (RS1_D),
    .RS2_D      (RS2_D),
    .RS1_E      (RS1_E),
    .RS2_E      (RS2_E),
    .RD_E       (RD_E),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .RD_M       (RD_M),
    .RegWriteM  (RegWriteM),
    .RD_W       (RD_W),
    .RegWriteW  (RegWriteW),
    .MemReqM    (MemReqM),
    .dmem_ready (dmem_ready),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .halt       (halt)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_count(stall_count),
    .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCnt++;
    if (actual !== expected) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [1:0] refFwd(input logic [4:0] src);
    if (RegWriteM && RD_M != 0 && RD_M == src) return 2'b10;
    if (RegWriteW && RD_W != 0 && RD_W == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clearIn();
    {RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W} = '0;
    {ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM} = '0;
    dmem_ready = 1'b0;
  endtask

  // One pipeline cycle: check combinational outputs mid-cycle, advance model after the edge.
  task automatic tick(input string name);
    logic [6:0] expCtrl, actCtrl;
    logic [1:0] expA, expB;
    logic       expHalt;
    bit         frz, lw, isBranch;
    @(negedge clk);
    #1;
    if (!rst) begin
      halted    = 1'b0;
      freezeRun = 0;
      mStall    = 0;
      mFlush    = 0;
    end
    frz      = MemReqM && !dmem_ready;
    lw       = ResultSrcE && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
    expA     = refFwd(RS1_E);
    expB     = refFwd(RS2_E);
    expCtrl  = 7'b0;
    expHalt  = 1'b0;
    isBranch = 1'b0;
    if (!rst) begin
      expA = 2'b00;
      expB = 2'b00;
    end else if (halted) begin
      expCtrl = 7'b1111_001;
      expHalt = 1'b1;
      expA    = 2'b00;
      expB    = 2'b00;
    end else if (frz) begin
      expCtrl = 7'b1111_001;
    end else if (PCSrcE) begin
      expCtrl  = 7'b0000_110;
      isBranch = 1'b1;
    end else if (lw) begin
      expCtrl = 7'b1100_010;
    end
    actCtrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    $display("[%0t] %s rst=%b fwd=%b/%b ctrl=%b halt=%b", $time, name, rst, ForwardAE, ForwardBE, actCtrl, halt);
    checkEq({name, ".fwdA"}, 32'(ForwardAE), 32'(expA));
    checkEq({name, ".fwdB"}, 32'(ForwardBE), 32'(expB));
    checkEq({name, ".ctrl"}, 32'(actCtrl), 32'(expCtrl));
    checkEq({name, ".halt"}, 32'(halt), 32'(expHalt));
`ifdef HAZARD_PERF_CNT_EN
    checkEq({name, ".stall_count"}, stall_count, mStall);
    checkEq({name, ".flush_count"}, flush_count, mFlush);
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      mStall += 32'(expCtrl[6]);
      mFlush += 32'(isBranch);
      if (!halted) begin
        freezeRun = frz ? freezeRun + 1 : 0;
        if (freezeRun >= TIMEOUT) halted = 1'b1;
      end
    end
  endtask

  initial begin
    clearIn();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      RS1_E = 5'($urandom_range(1, 3)); RD_M = RS1_E; RegWriteM = 1'b1;
      PCSrcE = 1'($urandom_range(0, 1)); MemReqM = 1'b1;
      tick("reset_hold");
    end
    rst = 1'b1;
    clearIn();

    RegWriteM = 1'b1; RD_M = 5; RS1_E = 5; RegWriteW = 1'b1; RD_W = 5;
    tick("fwd_mem_over_wb");
    RegWriteM = 1'b0;
    tick("fwd_wb");
    RegWriteM = 1'b1; RD_M = 0; RD_W = 0; RS1_E = 0;
    tick("fwd_x0");

    clearIn(); ResultSrcE = 1'b1; RD_E = 7; RS2_D = 7;
    tick("load_use");
    ResultSrcE = 1'b0;
    tick("load_use_done");
    ResultSrcE = 1'b1; PCSrcE = 1'b1;
    tick("branch_over_lw");

    clearIn(); MemReqM = 1'b1; PCSrcE = 1'b1;
    repeat (3) tick("mem_wait_branch");
    dmem_ready = 1'b1;
    tick("mem_ready_branch");
    clearIn();
    tick("idle");

    rst = 1'b0;
    tick("reset_perf");
    rst = 1'b1;
    repeat (4) begin
      ResultSrcE = 1'b1; RD_E = 3; RS1_D = 3;
      tick("perf_lw");
      clearIn();
      tick("perf_gap");
    end
    repeat (2) begin
      PCSrcE = 1'b1;
      tick("perf_branch");
      clearIn();
      tick("perf_gap");
    end
`ifdef HAZARD_PERF_CNT_EN
    checkEq("stall_count_4", stall_count, 32'd4);
    checkEq("flush_count_2", flush_count, 32'd2);
`endif

    MemReqM = 1'b1;
    repeat (15) tick("wait15");
    dmem_ready = 1'b1;
    tick("ready_after_15");
    checkEq("no_halt_after_15", 32'(halt), 32'd0);
    dmem_ready = 1'b0;
    repeat (16) tick("wait16");
    checkEq("halt_after_16", 32'(halt), 32'd1);
    dmem_ready = 1'b1; MemReqM = 1'b0; PCSrcE = 1'b1;
    repeat (2) tick("halt_sticky");
    rst = 1'b0;
    tick("reset_in_halt");
    rst = 1'b1;
    clearIn(); PCSrcE = 1'b1;
    tick("run_after_reset");

    for (int i = 0; i < 800; i++) begin
      if (halted && $urandom_range(0, 7) == 0) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0)    rst = 1'b0;
      else                                     rst = 1'b1;
      RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
      RS1_E = 5'($urandom_range(0, 3)); RS2_E = 5'($urandom_range(0, 3));
      RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
      RD_W  = 5'($urandom_range(0, 3));
      ResultSrcE = 1'($urandom_range(0, 1));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      if (burstLeft == 0 && $urandom_range(0, 59) == 0) burstLeft = int'($urandom_range(12, 20));
      if (burstLeft > 0) begin
        MemReqM = 1'b1; dmem_ready = 1'b0; burstLeft--;
      end else begin
        MemReqM    = ($urandom_range(0, 2) == 0);
        dmem_ready = 1'($urandom_range(0, 1));
      end
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule
